// File: rtl/vector_element_sequencer.sv
// Vector element sequencer: walks a vector instruction two elements per cycle and
// derives per-group register offsets for the selected SEW and destination widening.

package vector_element_sequencer_pkg;
    typedef enum logic [1:0] {
        SEW_8   = 2'b00,
        SEW_16  = 2'b01,
        SEW_32  = 2'b10,
        SEW_ILL = 2'b11
    } sew_t;
endpackage

module vector_element_sequencer
    import vector_element_sequencer_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       start,
    input  logic [7:0] vl,
    input  sew_t       sew,
    input  logic       vd_widen,
    input  logic       stall,
    input  logic       flush,
    output logic       ready,
    output logic       busy,
    output logic       elem_valid,
    output logic [7:0] elem_idx,
    output logic [1:0] lane_mask,
    output logic [2:0] vs_reg_off,
    output logic [2:0] vd_reg_off,
    output logic [3:0] elem_off,
    output logic       last,
    output logic       done
);

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned SUM_W  = IDX_W + 1;
    localparam int unsigned VL_MAX = 128;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] vl_q, vl_d;
    sew_t             sew_q, sew_d;
    logic             widen_q, widen_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] vl_clamped;
    logic             run;
    logic             last_c;
    logic [2:0]       vd_wide_off;

    assign vl_clamped = (vl > IDX_W'(VL_MAX)) ? IDX_W'(VL_MAX) : vl;
    assign run        = (state_q == RUN);
    // Final group once the pair reaches or passes the latched length.
    assign last_c     = run && ((SUM_W'(cnt_q) + SUM_W'(2)) >= SUM_W'(vl_q));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vl_q    <= '0;
            sew_q   <= SEW_8;
            widen_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vl_q    <= vl_d;
            sew_q   <= sew_d;
            widen_q <= widen_d;
            done_q  <= done_d;
        end
    end

    // Next state; flush outranks stall and start, and never produces done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vl_d    = vl_q;
        sew_d   = sew_q;
        widen_d = widen_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    vl_d    = vl_clamped;
                    sew_d   = sew;
                    widen_d = vd_widen;
                    cnt_d   = '0;
                    if ((vl_clamped == '0) || (sew == SEW_ILL)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!stall) begin
                    if (last_c) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(2);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Group outputs decode straight from the counter; all zero while idle.
    always_comb begin
        elem_valid  = 1'b0;
        elem_idx    = '0;
        lane_mask   = 2'b00;
        vs_reg_off  = '0;
        vd_wide_off = '0;
        elem_off    = '0;
        if (run) begin
            elem_valid = 1'b1;
            elem_idx   = cnt_q;
            lane_mask  = ((SUM_W'(cnt_q) + SUM_W'(1)) == SUM_W'(vl_q)) ? 2'b01 : 2'b11;
            case (sew_q)
                SEW_8: begin
                    vs_reg_off  = cnt_q[6:4];
                    elem_off    = cnt_q[3:0];
                    vd_wide_off = cnt_q[5:3];
                end
                SEW_16: begin
                    vs_reg_off  = cnt_q[5:3];
                    elem_off    = {1'b0, cnt_q[2:0]};
                    vd_wide_off = cnt_q[4:2];
                end
                SEW_32: begin
                    vs_reg_off  = cnt_q[4:2];
                    elem_off    = {2'b00, cnt_q[1:0]};
                    vd_wide_off = cnt_q[3:1];
                end
                default: begin
                    vs_reg_off  = '0;
                    elem_off    = '0;
                    vd_wide_off = '0;
                end
            endcase
        end
    end

    assign vd_reg_off = widen_q ? vd_wide_off : vs_reg_off;
    assign last       = last_c;
    assign done       = done_q;
    assign ready      = (state_q == IDLE);
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Scoreboard bench for vector_element_sequencer: directed scenarios push expected
// per-cycle group/done records; a negedge monitor pops and compares them.

module tb_vector_element_sequencer;
    import vector_element_sequencer_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       start = 1'b0;
    logic [7:0] vl = 8'd0;
    sew_t       sew = SEW_8;
    logic       vd_widen = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       ready, busy, elem_valid, last, done;
    logic [7:0] elem_idx;
    logic [1:0] lane_mask;
    logic [2:0] vs_reg_off, vd_reg_off;
    logic [3:0] elem_off;

    vector_element_sequencer dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (start),
        .vl        (vl),
        .sew       (sew),
        .vd_widen  (vd_widen),
        .stall     (stall),
        .flush     (flush),
        .ready     (ready),
        .busy      (busy),
        .elem_valid(elem_valid),
        .elem_idx  (elem_idx),
        .lane_mask (lane_mask),
        .vs_reg_off(vs_reg_off),
        .vd_reg_off(vd_reg_off),
        .elem_off  (elem_off),
        .last      (last),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] cyc;
        logic        is_done;
        logic [7:0]  idx;
        logic [1:0]  mask;
        logic [2:0]  vs;
        logic [2:0]  vd;
        logic [3:0]  eoff;
        logic        lst;
    } rec_t;

    rec_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc_n  = 0;

    // Hand-computed offsets for vl=20, sew=32b, widened destination (idx 0,2,..,18).
    logic [2:0] s2_vs[10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
    logic [3:0] s2_eo[10] = '{4'd0, 4'd2, 4'd0, 4'd2, 4'd0, 4'd2, 4'd0, 4'd2, 4'd0, 4'd2};
    logic [2:0] s2_vd[10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    initial forever begin
        @(posedge CLK);
        cyc_n++;
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push_grp(input int c, input logic [7:0] idx, input logic [1:0] m,
                            input logic [2:0] vs, input logic [2:0] vd,
                            input logic [3:0] eo, input logic l);
        rec_t r;
        r         = '0;
        r.cyc     = 32'(c);
        r.idx     = idx;
        r.mask    = m;
        r.vs      = vs;
        r.vd      = vd;
        r.eoff    = eo;
        r.lst     = l;
        exp_q.push_back(r);
    endtask

    task automatic push_done(input int c);
        rec_t r;
        r         = '0;
        r.cyc     = 32'(c);
        r.is_done = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [7:0] v, input sew_t s, input logic w, output int k);
        start    = 1'b1;
        vl       = v;
        sew      = s;
        vd_widen = w;
        k        = cyc_n;
    endtask

    task automatic check_idle(input string name);
        check_val(name, 32'({ready, busy, elem_valid, elem_idx, lane_mask, vs_reg_off,
                             vd_reg_off, elem_off, last, done}), 32'h0100_0000);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        repeat (2) @(posedge CLK);
        #1;
        check_val(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every presented group or done pulse must match the next expected record.
    initial forever begin
        rec_t a, e;
        @(negedge CLK);
        if (elem_valid === 1'b1 || done === 1'b1) begin
            a.cyc     = 32'(cyc_n);
            a.is_done = done;
            a.idx     = elem_idx;
            a.mask    = lane_mask;
            a.vs      = vs_reg_off;
            a.vd      = vd_reg_off;
            a.eoff    = elem_off;
            a.lst     = last;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: cyc %0d valid %b done %b idx %0d",
                         cyc_n, elem_valid, done, elem_idx);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL group: got cyc %0d done %b idx %0d mask %b vs %0d vd %0d eoff %0d last %b; expected cyc %0d done %b idx %0d mask %b vs %0d vd %0d eoff %0d last %b",
                             a.cyc, a.is_done, a.idx, a.mask, a.vs, a.vd, a.eoff, a.lst,
                             e.cyc, e.is_done, e.idx, e.mask, e.vs, e.vd, e.eoff, e.lst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, k2, b;

        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset_state");
        nRST = 1'b1;

        // vl=5, 8b: three groups, odd tail, start taken on first edge after release
        issue(8'd5, SEW_8, 1'b0, k);
        push_grp(k + 1, 8'd0, 2'b11, 3'd0, 3'd0, 4'd0, 1'b0);
        push_grp(k + 2, 8'd2, 2'b11, 3'd0, 3'd0, 4'd2, 1'b0);
        push_grp(k + 3, 8'd4, 2'b01, 3'd0, 3'd0, 4'd4, 1'b1);
        push_done(k + 4);
        step();
        start = 1'b0;
        b = 0;
        repeat (4) begin
            if (busy) b++;
            step();
        end
        check_val("s1_busy_cycles", 32'(b), 32'd3);
        drain("s1_drain");

        // vl=20, 32b, widened destination with truncated offset
        issue(8'd20, SEW_32, 1'b1, k);
        for (int i = 0; i < 10; i++)
            push_grp(k + 1 + i, 8'(2 * i), 2'b11, s2_vs[i], s2_vd[i], s2_eo[i], i == 9);
        push_done(k + 11);
        step();
        start = 1'b0;
        drain("s2_drain");

        // vl=6, 16b, stall three cycles on the second group
        issue(8'd6, SEW_16, 1'b0, k);
        push_grp(k + 1, 8'd0, 2'b11, 3'd0, 3'd0, 4'd0, 1'b0);
        for (int i = 2; i <= 5; i++)
            push_grp(k + i, 8'd2, 2'b11, 3'd0, 3'd0, 4'd2, 1'b0);
        push_grp(k + 6, 8'd4, 2'b11, 3'd0, 3'd0, 4'd4, 1'b1);
        push_done(k + 7);
        step();
        start = 1'b0;
        step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        drain("s3_drain");

        // vl=0 then sew=11 presented in the done cycle: back-to-back done pulses
        issue(8'd0, SEW_8, 1'b0, k);
        push_done(k + 1);
        step();
        check_val("s4_ready_vl0", 32'(ready), 32'd1);
        issue(8'd5, SEW_ILL, 1'b0, k2);
        push_done(k2 + 1);
        step();
        start = 1'b0;
        check_val("s4_ready_ill", 32'(ready), 32'd1);
        drain("s4_drain");

        // vl=8 flushed on its last group, then restarted the next cycle
        issue(8'd8, SEW_8, 1'b0, k);
        for (int i = 0; i < 4; i++)
            push_grp(k + 1 + i, 8'(2 * i), 2'b11, 3'd0, 3'd0, 4'(2 * i), i == 3);
        step();
        start = 1'b0;
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("s5_flush_idle", 32'({ready, busy, done}), 32'b100);
        issue(8'd8, SEW_8, 1'b0, k);
        for (int i = 0; i < 4; i++)
            push_grp(k + 1 + i, 8'(2 * i), 2'b11, 3'd0, 3'd0, 4'(2 * i), i == 3);
        push_done(k + 5);
        step();
        start = 1'b0;
        drain("s5_drain");

        // asynchronous reset mid-run at idx 4
        issue(8'd10, SEW_8, 1'b0, k);
        push_grp(k + 1, 8'd0, 2'b11, 3'd0, 3'd0, 4'd0, 1'b0);
        push_grp(k + 2, 8'd2, 2'b11, 3'd0, 3'd0, 4'd2, 1'b0);
        push_grp(k + 3, 8'd4, 2'b11, 3'd0, 3'd0, 4'd4, 1'b0);
        step();
        start = 1'b0;
        step();
        step();
        #6;
        nRST = 1'b0;
        #1;
        check_idle("s6_async_reset");
        step();
        check_idle("s6_reset_hold");
        #2;
        nRST = 1'b1;
        step();
        check_idle("s6_after_release");
        drain("s6_drain");

        // vl=200 clamps to 128: 64 groups, last at idx 126
        issue(8'd200, SEW_8, 1'b1, k);
        for (int i = 0; i < 64; i++)
            push_grp(k + 1 + i, 8'(2 * i), 2'b11, 3'((2 * i) / 16), 3'(((2 * i) / 8) % 8),
                     4'((2 * i) % 16), i == 63);
        push_done(k + 65);
        step();
        start = 1'b0;
        drain("s7_drain");

        // vl=3, 16b widened: odd tail on the second group
        issue(8'd3, SEW_16, 1'b1, k);
        push_grp(k + 1, 8'd0, 2'b11, 3'd0, 3'd0, 4'd0, 1'b0);
        push_grp(k + 2, 8'd2, 2'b01, 3'd0, 3'd0, 4'd2, 1'b1);
        push_done(k + 3);
        step();
        start = 1'b0;
        drain("s8_drain");
        check_idle("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
